rf_wb_ctrl: RTL and testbench

- Write-back controller on the write side of the register file.
- Merges two result sources into the single RF write port (RFWr/A3/WD): single-cycle ALU results, and queued multi-cycle results such as loads and mult/div.
- Keeps a 32-entry pending-write scoreboard so decode can stall on operands whose producer has not yet written back.

---
 rtl/rf_wb_ctrl.sv | 128 ++++++++++++
 tb/tb_rf_wb_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: merges ALU and queued slow-path results onto the RF write port
// and tracks pending destination writes. Optional bypass of in-flight writes: WB_BYPASS_EN.
module rf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alu_we,
    input  logic [4:0]    alu_addr,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    input  logic [4:0]    mem_addr,
    input  logic [31:0]   mem_data,
    output logic          mem_ready,
    input  logic          rsv_valid,
    input  logic [4:0]    rsv_addr,
    input  logic [4:0]    q1_addr,
    input  logic [4:0]    q2_addr,
    output logic          q1_busy,
    output logic          q2_busy,
    output logic          q1_fwd,
    output logic          q2_fwd,
    output logic [31:0]   q1_fwd_data,
    output logic [31:0]   q2_fwd_data,
    output logic          RFWr,
    output logic [4:0]    A3,
    output logic [31:0]   WD,
    output logic [AW:0]   fifo_count
);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [4:0]    fa_q [DEPTH];
    logic [31:0]   fd_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          we_q;
    logic [4:0]    a3_q;
    logic [31:0]   wd_q;
    logic [31:0]   pend_q, pend_d;
    logic          alu_sel, push, pop;

    assign mem_ready = (cnt_q < FULL);
    // r0 writes are accepted but never queued.
    assign push      = mem_valid && mem_ready && (mem_addr != 5'd0);
    assign alu_sel   = alu_we && (alu_addr != 5'd0);
    assign pop       = !alu_sel && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wptr_q] <= mem_addr;
            fd_q[wptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd_q   <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            we_q  <= alu_sel || pop;
            if (alu_sel) begin
                a3_q <= alu_addr;
                wd_q <= alu_data;
            end else if (pop) begin
                a3_q <= fa_q[rptr_q];
                wd_q <= fd_q[rptr_q];
            end else begin
                a3_q <= '0;
                wd_q <= '0;
            end
        end
    end

    // Clear on the edge the RF commits; a same-edge reservation re-arms the entry.
    always_comb begin
        pend_d = pend_q;
        if (we_q)
            pend_d[a3_q] = 1'b0;
        if (rsv_valid && (rsv_addr != 5'd0))
            pend_d[rsv_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    assign RFWr       = we_q;
    assign A3         = a3_q;
    assign WD         = wd_q;
    assign fifo_count = cnt_q;

`ifdef WB_BYPASS_EN
    assign q1_fwd      = we_q && (a3_q != 5'd0) && (a3_q == q1_addr);
    assign q2_fwd      = we_q && (a3_q != 5'd0) && (a3_q == q2_addr);
    assign q1_fwd_data = q1_fwd ? wd_q : 32'd0;
    assign q2_fwd_data = q2_fwd ? wd_q : 32'd0;
    assign q1_busy     = pend_q[q1_addr] && !q1_fwd;
    assign q2_busy     = pend_q[q2_addr] && !q2_fwd;
`else
    assign q1_fwd      = 1'b0;
    assign q2_fwd      = 1'b0;
    assign q1_fwd_data = 32'd0;
    assign q2_fwd_data = 32'd0;
    assign q1_busy     = pend_q[q1_addr];
    assign q2_busy     = pend_q[q2_addr];
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: ALU path, FIFO fill/drain/wrap, scoreboard, bypass, async reset.
module tb_rf_wb_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_we, mem_valid, rsv_valid;
    logic [4:0]  alu_addr, mem_addr, rsv_addr, q1_addr, q2_addr;
    logic [31:0] alu_data, mem_data;
    logic        mem_ready, q1_busy, q2_busy, q1_fwd, q2_fwd, RFWr;
    logic [31:0] q1_fwd_data, q2_fwd_data, WD;
    logic [4:0]  A3;
    logic [2:0]  fifo_count;
    logic [31:0] rf [32];
    int nvec = 0;
    int nfail = 0;

    rf_wb_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rstn(rstn),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .q1_addr(q1_addr), .q2_addr(q2_addr),
        .q1_busy(q1_busy), .q2_busy(q2_busy), .q1_fwd(q1_fwd), .q2_fwd(q2_fwd),
        .q1_fwd_data(q1_fwd_data), .q2_fwd_data(q2_fwd_data),
        .RFWr(RFWr), .A3(A3), .WD(WD), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Register file model sitting behind the write port.
    always @(posedge clk) if (RFWr) rf[A3] <= WD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; alu_we = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        rsv_valid = 0; rsv_addr = 0; q1_addr = 0; q2_addr = 0;
        #12;
        chk("rst_RFWr", 32'(RFWr), 0);
        chk("rst_A3", 32'(A3), 0);
        chk("rst_WD", WD, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(mem_ready), 1);
        chk("rst_busy", 32'(q1_busy), 0);
        chk("rst_fwd", 32'(q1_fwd), 0);
        rstn = 1'b1;
        tick();

        // ALU path
        alu_we = 1; alu_addr = 5; alu_data = 32'h12345678;
        tick();
        alu_we = 0;
        chk("alu_RFWr", 32'(RFWr), 1);
        chk("alu_A3", 32'(A3), 5);
        chk("alu_WD", WD, 32'h12345678);
        tick();
        chk("alu_rf5", rf[5], 32'h12345678);
        chk("alu_idle", 32'(RFWr), 0);

        alu_we = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
        tick();
        alu_we = 0;
        chk("r0_RFWr_a", 32'(RFWr), 0);
        tick();
        chk("r0_RFWr_b", 32'(RFWr), 0);

        // FIFO fill while ALU hogs the port
        alu_we = 1; alu_addr = 20; alu_data = 32'h55;
        mem_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            mem_addr = 5'(i); mem_data = 32'h100 + 32'(i);
            tick();
            if (i == 4) chk("fill_ready4", 32'(mem_ready), 0);
        end
        mem_valid = 0; alu_we = 0;
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_ready", 32'(mem_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_RFWr", 32'(RFWr), 1);
            chk("drain_A3", 32'(A3), 32'(i));
            chk("drain_WD", WD, 32'h100 + 32'(i));
            chk("drain_count", 32'(fifo_count), 32'(4 - i));
            chk("drain_ready", 32'(mem_ready), 1);
        end
        tick();
        chk("drain_done", 32'(RFWr), 0);

        // Simultaneous push/pop at count 2, wrapping pointers
        alu_we = 1; alu_addr = 20;
        mem_valid = 1;
        mem_addr = 1; tick();
        mem_addr = 2; tick();
        alu_we = 0;
        chk("pp_count0", 32'(fifo_count), 2);
        for (int i = 3; i <= 6; i++) begin
            mem_addr = 5'(i); mem_data = 32'h200 + 32'(i);
            tick();
            chk("pp_count", 32'(fifo_count), 2);
            chk("pp_A3", 32'(A3), 32'(i - 2));
        end
        mem_valid = 0;
        tick();
        chk("pp_A3_5", 32'(A3), 5);
        chk("pp_count1", 32'(fifo_count), 1);
        tick();
        chk("pp_A3_6", 32'(A3), 6);
        chk("pp_WD_6", WD, 32'h206);
        chk("pp_count_e", 32'(fifo_count), 0);
        tick();

        // Scoreboard
        rsv_valid = 1; rsv_addr = 9; q1_addr = 9;
        tick();
        rsv_valid = 0;
        chk("sb_busy_set", 32'(q1_busy), 1);
        mem_valid = 1; mem_addr = 9; mem_data = 32'hAA;
        tick();
        mem_valid = 0;
        chk("sb_busy_q", 32'(q1_busy), 1);
        tick();
        chk("sb_wr9", 32'(A3), 9);
`ifdef WB_BYPASS_EN
        chk("sb_busy_wr", 32'(q1_busy), 0);
`else
        chk("sb_busy_wr", 32'(q1_busy), 1);
`endif
        rsv_valid = 1; rsv_addr = 9;
        tick();
        rsv_valid = 0;
        chk("sb_set_wins", 32'(q1_busy), 1);
        mem_valid = 1; mem_addr = 9; mem_data = 32'hBB;
        tick();
        mem_valid = 0;
        tick();
        tick();
        chk("sb_cleared", 32'(q1_busy), 0);
        q1_addr = 0;
        #1 chk("sb_r0", 32'(q1_busy), 0);

        // Bypass
        alu_we = 1; alu_addr = 7; alu_data = 32'hCAFEF00D;
        rsv_valid = 1; rsv_addr = 7;
        tick();
        alu_we = 0; rsv_valid = 0; q2_addr = 7;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_fwd", 32'(q2_fwd), 1);
        chk("byp_data", q2_fwd_data, 32'hCAFEF00D);
        chk("byp_busy", 32'(q2_busy), 0);
`else
        chk("byp_fwd", 32'(q2_fwd), 0);
        chk("byp_data", q2_fwd_data, 0);
        chk("byp_busy", 32'(q2_busy), 1);
`endif
        tick();
        chk("byp_after", 32'(q2_busy), 0);

        // Async reset mid-operation
        rsv_valid = 1; rsv_addr = 12; q1_addr = 12; q2_addr = 12;
        alu_we = 1; alu_addr = 21; alu_data = 32'h77;
        mem_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            mem_addr = 5'(10 + i);
            tick();
            rsv_valid = 0;
        end
        chk("ar_pre_count", 32'(fifo_count), 3);
        chk("ar_pre_RFWr", 32'(RFWr), 1);
        chk("ar_pre_busy", 32'(q1_busy), 1);
        #1 rstn = 1'b0;
        #1;
        chk("ar_RFWr", 32'(RFWr), 0);
        chk("ar_count", 32'(fifo_count), 0);
        chk("ar_busy1", 32'(q1_busy), 0);
        chk("ar_busy2", 32'(q2_busy), 0);
        chk("ar_ready", 32'(mem_ready), 1);
        alu_we = 0; mem_valid = 0;
        tick();
        rstn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
